fwd_hazard_scoreboard: RTL and testbench
========================================

# fwd_hazard_scoreboard

Parametrised forwarding and hazard scoreboard for the in-order pipelined datapath. It tracks every in-flight register write from EX to WB in a DEPTH-entry shift register. From that state it produces per-operand forward selects for the instruction in EX and a load-use stall for the instruction in decode. It generalises the fixed 5-stage forward/hazard pair to any pipeline depth, load latency and source-operand count, and adds squash and stall accounting.

## Interface
Parameters:
- RBITS, 5: register index width; register 0 is hard-wired zero.
- DEPTH, 3: number of tracked stages; stage 1 = EX, stage DEPTH = WB.
- LOAD_READY, 3: first stage at which load data is forwardable (2..DEPTH).
- NSRC, 2: source operands per instruction.
- SELW, $clog2(DEPTH+1): forward-select width.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- advance  in  1  pipeline moves this cycle; 0 = all stages hold (cache miss).
- issue_valid  in  1  decode instruction wants to enter EX.
- issue_wen  in  1  issuing instruction writes a register.
- issue_load  in  1  issuing instruction is a load.
- issue_wsel  in  RBITS  destination register.
- dec_src  in  NSRC*RBITS  decode source registers, operand i at [i*RBITS +: RBITS].
- dec_src_used  in  NSRC  source i is actually read.
- flush_dec  in  1  squash the issuing instruction.
- flush_mask  in  DEPTH  bit k-1 squashes the current stage-k entry.
- stall  out  1  load-use hazard; datapath holds PC and IF/ID.
- fwd_sel  out  NSRC*SELW  per EX operand: 0 = register file, k = value from stage k (2..DEPTH).
- stall_cnt  out  16  saturating count of stall cycles.

## Operation
- Entry fields: valid, wen, load, wsel, src[NSRC], src_used[NSRC]. Bubble = valid 0.
- "Match" of register r at stage k: valid && wen && wsel==r && r!=0. "Youngest" = lowest k.
- stall, combinational: 1 iff for some used decode source the youngest match in stages 1..DEPTH-1 is a load with k+1 < LOAD_READY. Matches at stage DEPTH do not cause a stall, because they retire at this edge. Any used source with r = 0 never stalls.
- fwd_sel[i], combinational from the stage-1 entry: taken from the youngest match of src[i] in stages 2..DEPTH, and only if src_used[i]. Otherwise 0. An older match never overrides a younger one.
- Clock edge, advance = 1:
  - stage k+1 <= stage k for k = 1..DEPTH-1.
  - Stage DEPTH retires.
  - Stage 1 <= issue fields if issue_valid && !stall && !flush_dec; otherwise a bubble.
- Clock edge, advance = 0: all entries hold and issue is ignored.
- flush_mask is applied to current contents before the shift. A squashed entry moves, or holds, as a bubble. flush_mask acts even when advance = 0.
- stall_cnt increments on every edge where stall && issue_valid, and saturates at 16'hFFFF.
- RST: all entries become bubbles, so stall = 0 and fwd_sel = 0; stall_cnt = 0. RST overrides advance, issue and flush in the same cycle.

## Timing
- fwd_sel and stall are valid in the same cycle as the state and inputs; there are no registered outputs except stall_cnt.
- Load-use bubbles equal LOAD_READY-2 for an immediately dependent instruction. With defaults this is 1 cycle.
- An ALU producer followed directly by its consumer gives fwd_sel = 2 in the consumer's EX cycle. With one gap it gives 3 (WB).
- Simultaneous flush_mask of a stalling load and stall evaluation: stall still reflects pre-edge state for that cycle and deasserts the next cycle.
- A hazard persists across advance = 0 cycles. stall_cnt still counts those cycles if issue_valid.

## Test plan
- Defaults. Issue add r3, next cycle issue sub with src r3 -> stall = 0; during sub's EX, fwd_sel[0] = 2. Insert a bubble between them -> fwd_sel[0] = 3.
- Defaults. Issue lw r5, next cycle decode uses r5 -> stall = 1 for exactly one cycle, stall_cnt = 1; consumer's EX shows fwd_sel = 3.
- DEPTH = 5, LOAD_READY = 4, lw r9 then consumer of r9 -> stall high for 2 cycles, then fwd_sel = 4. Hold advance = 0 for 3 cycles mid-stall -> stall stays 1, stall_cnt ends at 5.
- Producers of r7 at stages 2 and 3 and consumer in EX reading r7 -> fwd_sel = 2. Repeat with r0 as destination and source -> fwd_sel = 0, stall = 0.
- lw r4 in stage 1, consumer in decode, flush_mask = 3'b001 -> stall = 1 that cycle, 0 next cycle; consumer's EX shows fwd_sel = 0.
- Assert RST with three valid entries and stall_cnt = 7 -> next cycle all fwd_sel = 0, stall = 0, stall_cnt = 0.

Source files
------------

// File: rtl/fwd_hazard_scoreboard_if.sv
// Decode/issue, flush and forwarding signals shared between the datapath
// control (master) and the forwarding/hazard scoreboard (slave).
interface fwd_hazard_scoreboard_if #(
    parameter int RBITS = 5,
    parameter int DEPTH = 3,
    parameter int NSRC  = 2,
    parameter int SELW  = $clog2(DEPTH + 1)
);
    logic                    advance;
    logic                    issue_valid;
    logic                    issue_wen;
    logic                    issue_load;
    logic [RBITS-1:0]        issue_wsel;
    logic [NSRC*RBITS-1:0]   dec_src;
    logic [NSRC-1:0]         dec_src_used;
    logic                    flush_dec;
    logic [DEPTH-1:0]        flush_mask;
    logic                    stall;
    logic [NSRC*SELW-1:0]    fwd_sel;
    logic [15:0]             stall_cnt;

    modport master (
        output advance, issue_valid, issue_wen, issue_load, issue_wsel,
               dec_src, dec_src_used, flush_dec, flush_mask,
        input  stall, fwd_sel, stall_cnt
    );

    modport slave (
        input  advance, issue_valid, issue_wen, issue_load, issue_wsel,
               dec_src, dec_src_used, flush_dec, flush_mask,
        output stall, fwd_sel, stall_cnt
    );
endinterface

// File: rtl/fwd_hazard_scoreboard.sv
// Tracks in-flight register writes from EX (stage 1) to WB (stage DEPTH) and
// derives per-operand forward selects plus a load-use stall for decode.
module fwd_hazard_scoreboard #(
    parameter int RBITS      = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 3,
    parameter int NSRC       = 2,
    parameter int SELW       = $clog2(DEPTH + 1)
) (
    input  logic                   CLK,
    input  logic                   RST,
    fwd_hazard_scoreboard_if.slave sb
);

    // Index k holds the stage-(k+1) entry.
    logic [DEPTH-1:0]       valid_q, valid_d;
    logic [DEPTH-1:0]       wen_q, wen_d;
    logic [DEPTH-1:0]       load_q, load_d;
    logic [DEPTH-1:0]       valid_m;
    logic [RBITS-1:0]       wsel_q [DEPTH];
    logic [RBITS-1:0]       wsel_d [DEPTH];
    logic [NSRC*RBITS-1:0]  src_q  [DEPTH];
    logic [NSRC*RBITS-1:0]  src_d  [DEPTH];
    logic [NSRC-1:0]        used_q [DEPTH];
    logic [NSRC-1:0]        used_d [DEPTH];
    logic [15:0]            stall_cnt_q, stall_cnt_d;

    logic                   stall_c;
    logic                   issue_ok;
    logic [NSRC*SELW-1:0]   fwd_c;

    logic [RBITS-1:0]       dec_r;
    logic                   dec_found;
    logic                   dec_hit;
    logic [RBITS-1:0]       ex_r;
    logic                   ex_found;
    logic [SELW-1:0]        ex_sel;

    // Stage DEPTH is excluded: it retires at this edge and its value reaches
    // the consumer through the register file.
    always_comb begin
        stall_c   = 1'b0;
        dec_r     = '0;
        dec_found = 1'b0;
        dec_hit   = 1'b0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            dec_r     = sb.dec_src[i*RBITS +: RBITS];
            dec_found = 1'b0;
            dec_hit   = 1'b0;
            for (int unsigned k = 0; k < DEPTH - 1; k++) begin
                if (!dec_found && valid_q[k] && wen_q[k] && (wsel_q[k] == dec_r)) begin
                    dec_found = 1'b1;
                    dec_hit   = load_q[k] && (k + 2 < LOAD_READY);
                end
            end
            if (sb.dec_src_used[i] && (dec_r != '0) && dec_hit) begin
                stall_c = 1'b1;
            end
        end
    end

    always_comb begin
        fwd_c    = '0;
        ex_r     = '0;
        ex_found = 1'b0;
        ex_sel   = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            ex_r     = src_q[0][i*RBITS +: RBITS];
            ex_found = 1'b0;
            ex_sel   = '0;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                if (!ex_found && valid_q[k] && wen_q[k] && (wsel_q[k] == ex_r)) begin
                    ex_found = 1'b1;
                    ex_sel   = SELW'(k + 1);
                end
            end
            if (valid_q[0] && used_q[0][i] && (ex_r != '0)) begin
                fwd_c[i*SELW +: SELW] = ex_sel;
            end
        end
    end

    assign issue_ok = sb.issue_valid && !stall_c && !sb.flush_dec;

    // Squash is applied before the shift so a flushed entry travels (or holds)
    // as a bubble, independent of advance.
    always_comb begin
        valid_m = valid_q & ~sb.flush_mask;
        valid_d = valid_m;
        wen_d   = wen_q;
        load_d  = load_q;
        wsel_d  = wsel_q;
        src_d   = src_q;
        used_d  = used_q;
        if (sb.advance) begin
            for (int unsigned k = 1; k < DEPTH; k++) begin
                valid_d[k] = valid_m[k-1];
                wen_d[k]   = wen_q[k-1];
                load_d[k]  = load_q[k-1];
                wsel_d[k]  = wsel_q[k-1];
                src_d[k]   = src_q[k-1];
                used_d[k]  = used_q[k-1];
            end
            valid_d[0] = issue_ok;
            wen_d[0]   = issue_ok & sb.issue_wen;
            load_d[0]  = issue_ok & sb.issue_load;
            wsel_d[0]  = issue_ok ? sb.issue_wsel   : '0;
            src_d[0]   = issue_ok ? sb.dec_src      : '0;
            used_d[0]  = issue_ok ? sb.dec_src_used : '0;
        end

        stall_cnt_d = stall_cnt_q;
        if (stall_c && sb.issue_valid && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q     <= '0;
            wen_q       <= '0;
            load_q      <= '0;
            wsel_q      <= '{default: '0};
            src_q       <= '{default: '0};
            used_q      <= '{default: '0};
            stall_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            wen_q       <= wen_d;
            load_q      <= load_d;
            wsel_q      <= wsel_d;
            src_q       <= src_d;
            used_q      <= used_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign sb.stall     = stall_c;
    assign sb.fwd_sel   = fwd_c;
    assign sb.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Directed bench: default configuration (DEPTH=3) plus a DEPTH=5/LOAD_READY=4
// instance; expectations are queued per cycle and checked at the falling edge.
module tb_fwd_hazard_scoreboard;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    always #5 CLK = ~CLK;

    fwd_hazard_scoreboard_if #(.RBITS(5), .DEPTH(3), .NSRC(2)) ia ();
    fwd_hazard_scoreboard_if #(.RBITS(5), .DEPTH(5), .NSRC(2)) ib ();

    fwd_hazard_scoreboard #(.RBITS(5), .DEPTH(3), .LOAD_READY(3), .NSRC(2)) dut_a (
        .CLK (CLK),
        .RST (RST),
        .sb  (ia)
    );

    fwd_hazard_scoreboard #(.RBITS(5), .DEPTH(5), .LOAD_READY(4), .NSRC(2)) dut_b (
        .CLK (CLK),
        .RST (RST),
        .sb  (ib)
    );

    typedef struct {
        int          dut;
        int          fld;
        logic [31:0] val;
    } exp_t;

    exp_t  exp_q [$];
    string tag_q [$];
    int    n_cmp = 0;
    int    n_mis = 0;

    // fld: 0 = stall, 1 = fwd_sel operand 0, 2 = fwd_sel operand 1, 3 = stall_cnt
    function automatic logic [31:0] observe(input int d, input int f);
        if (d == 0) begin
            case (f)
                0:       return 32'(ia.stall);
                1:       return 32'(ia.fwd_sel[1:0]);
                2:       return 32'(ia.fwd_sel[3:2]);
                default: return 32'(ia.stall_cnt);
            endcase
        end else begin
            case (f)
                0:       return 32'(ib.stall);
                1:       return 32'(ib.fwd_sel[2:0]);
                2:       return 32'(ib.fwd_sel[5:3]);
                default: return 32'(ib.stall_cnt);
            endcase
        end
    endfunction

    task automatic push(input string t, input int d, input int f, input int v);
        exp_t e;
        if (v >= 0) begin
            e.dut = d;
            e.fld = f;
            e.val = 32'(v);
            exp_q.push_back(e);
            tag_q.push_back(t);
        end
    endtask

    // Negative values mean "not checked this cycle".
    task automatic expect_all(input int d, input string t, input int st,
                              input int f0, input int f1, input int c);
        push({t, ".stall"}, d, 0, st);
        push({t, ".fwd0"},  d, 1, f0);
        push({t, ".fwd1"},  d, 2, f1);
        push({t, ".cnt"},   d, 3, c);
    endtask

    task automatic step();
        exp_t        e;
        string       t;
        logic [31:0] o;
        @(negedge CLK);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            o = observe(e.dut, e.fld);
            n_cmp++;
            assert (o === e.val) else begin
                n_mis++;
                $error("FAIL %s observed=%0d expected=%0d", t, o, e.val);
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic drv_a(input logic v, input logic w, input logic l, input logic [4:0] ws,
                         input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used);
        ia.advance      = 1'b1;
        ia.issue_valid  = v;
        ia.issue_wen    = w;
        ia.issue_load   = l;
        ia.issue_wsel   = ws;
        ia.dec_src      = {s1, s0};
        ia.dec_src_used = used;
        ia.flush_dec    = 1'b0;
        ia.flush_mask   = '0;
    endtask

    task automatic drv_b(input logic v, input logic w, input logic l, input logic [4:0] ws,
                         input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used);
        ib.advance      = 1'b1;
        ib.issue_valid  = v;
        ib.issue_wen    = w;
        ib.issue_load   = l;
        ib.issue_wsel   = ws;
        ib.dec_src      = {s1, s0};
        ib.dec_src_used = used;
        ib.flush_dec    = 1'b0;
        ib.flush_mask   = '0;
    endtask

    initial begin
        drv_a(0, 0, 0, 0, 0, 0, 2'b00);
        drv_b(0, 0, 0, 0, 0, 0, 2'b00);

        // reset state
        expect_all(0, "rst_a", 0, 0, 0, 0);
        expect_all(1, "rst_b", 0, 0, 0, 0);
        step();
        RST = 1'b0;

        // ALU producer then direct consumer
        drv_a(1, 1, 0, 3, 1, 2, 2'b11);
        expect_all(0, "alu_prod", 0, -1, -1, 0);
        step();
        drv_a(1, 1, 0, 6, 3, 4, 2'b11);
        expect_all(0, "alu_cons_dec", 0, 0, 0, -1);
        step();
        drv_a(0, 0, 0, 0, 0, 0, 2'b00);
        expect_all(0, "alu_fwd_ex", -1, 2, 0, -1);
        step();

        // one bubble between producer and consumer (operand 1 reads r3)
        drv_a(1, 1, 0, 3, 1, 2, 2'b11);
        step();
        drv_a(0, 0, 0, 0, 0, 0, 2'b00);
        step();
        drv_a(1, 1, 0, 8, 5, 3, 2'b11);
        expect_all(0, "gap_dec", 0, -1, -1, -1);
        step();
        drv_a(0, 0, 0, 0, 0, 0, 2'b00);
        expect_all(0, "gap_fwd", -1, 0, 3, -1);
        step();

        // unused operand does not forward
        drv_a(1, 1, 0, 9, 1, 1, 2'b11);
        step();
        drv_a(1, 1, 0, 10, 9, 9, 2'b10);
        step();
        drv_a(0, 0, 0, 0, 0, 0, 2'b00);
        expect_all(0, "used_gate", -1, 0, 2, -1);
        step();

        // load-use: one stall cycle, then forward from WB
        drv_a(1, 1, 1, 5, 1, 2, 2'b01);
        expect_all(0, "lu_load", 0, -1, -1, 0);
        step();
        drv_a(1, 1, 0, 11, 5, 2, 2'b01);
        expect_all(0, "lu_stall", 1, -1, -1, 0);
        step();
        expect_all(0, "lu_release", 0, -1, -1, 1);
        step();
        drv_a(0, 0, 0, 0, 0, 0, 2'b00);
        expect_all(0, "lu_fwd", 0, 3, 0, 1);
        step();

        // two producers of r7: youngest wins
        drv_a(1, 1, 0, 7, 1, 2, 2'b11);
        step();
        drv_a(1, 1, 0, 7, 1, 2, 2'b11);
        step();
        drv_a(1, 1, 0, 12, 7, 7, 2'b11);
        step();
        drv_a(0, 0, 0, 0, 0, 0, 2'b00);
        expect_all(0, "youngest", 0, 2, 2, -1);
        step();

        // r0 never stalls or forwards
        drv_a(1, 1, 1, 0, 1, 2, 2'b01);
        step();
        drv_a(1, 1, 0, 13, 0, 0, 2'b11);
        expect_all(0, "r0_nostall", 0, -1, -1, 1);
        step();
        drv_a(0, 0, 0, 0, 0, 0, 2'b00);
        expect_all(0, "r0_nofwd", 0, 0, 0, -1);
        step();

        // flushing a stalling load in stage 1
        drv_a(1, 1, 1, 4, 1, 2, 2'b01);
        step();
        drv_a(1, 1, 0, 14, 4, 1, 2'b01);
        ia.flush_mask = 3'b001;
        expect_all(0, "flush_stall", 1, -1, -1, 1);
        step();
        drv_a(1, 1, 0, 14, 4, 1, 2'b01);
        expect_all(0, "flush_release", 0, -1, -1, 2);
        step();
        drv_a(0, 0, 0, 0, 0, 0, 2'b00);
        expect_all(0, "flush_fwd", 0, 0, -1, 2);
        step();

        // flush_dec turns the issuing producer into a bubble
        drv_a(1, 1, 0, 15, 1, 2, 2'b11);
        ia.flush_dec = 1'b1;
        step();
        drv_a(1, 1, 0, 16, 15, 1, 2'b01);
        step();
        drv_a(0, 0, 0, 0, 0, 0, 2'b00);
        expect_all(0, "flush_dec", -1, 0, -1, -1);
        step();

        // three valid entries, hazard held across advance=0, then reset
        drv_a(1, 1, 0, 10, 1, 2, 2'b11);
        step();
        drv_a(1, 1, 0, 11, 1, 2, 2'b11);
        step();
        drv_a(1, 1, 1, 12, 11, 10, 2'b11);
        step();
        for (int k = 0; k < 5; k++) begin
            drv_a(1, 1, 0, 17, 12, 1, 2'b01);
            ia.advance = 1'b0;
            expect_all(0, $sformatf("hold%0d", k), 1, 2, 3, 2 + k);
            step();
        end
        drv_a(1, 1, 0, 17, 12, 1, 2'b01);
        ia.flush_mask = 3'b111;
        RST = 1'b1;
        expect_all(0, "pre_rst", 1, 2, 3, 7);
        step();
        expect_all(0, "post_rst", 0, 0, 0, 0);
        step();
        RST = 1'b0;
        drv_a(0, 0, 0, 0, 0, 0, 2'b00);

        // DEPTH=5, LOAD_READY=4: two stall cycles plus three held cycles
        drv_b(1, 1, 1, 9, 1, 2, 2'b01);
        expect_all(1, "b_load", 0, -1, -1, 0);
        step();
        drv_b(1, 1, 0, 2, 9, 1, 2'b01);
        expect_all(1, "b_stall0", 1, -1, -1, 0);
        step();
        for (int k = 0; k < 3; k++) begin
            drv_b(1, 1, 0, 2, 9, 1, 2'b01);
            ib.advance = 1'b0;
            expect_all(1, $sformatf("b_hold%0d", k), 1, -1, -1, 1 + k);
            step();
        end
        drv_b(1, 1, 0, 2, 9, 1, 2'b01);
        expect_all(1, "b_stall1", 1, -1, -1, 4);
        step();
        drv_b(1, 1, 0, 2, 9, 1, 2'b01);
        expect_all(1, "b_release", 0, -1, -1, 5);
        step();
        drv_b(0, 0, 0, 0, 0, 0, 2'b00);
        expect_all(1, "b_fwd", 0, 4, 0, 5);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
